// File: rtl/regdst_hazard_pipe_pkg.sv
// Shared constants for the destination-register tracking pipeline:
// EX forwarding-select encodings and the bit layout of a stage slot record.
package regdst_hazard_pipe_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Slot record: {wreg, wen, valid}, with wreg occupying the top NREG_W bits.
    // The EX stage keeps its is_load flag and source fields alongside the record.
    localparam int SLOT_VALID    = 0;
    localparam int SLOT_WEN      = 1;
    localparam int SLOT_WREG_LSB = 2;

endpackage

// File: rtl/regdst_hazard_pipe_fwd_cmp.sv
// Forwarding select for one EX operand: compares its source register against
// the MEM and WB destinations, with MEM taking priority and r0 never forwarding.
module fwd_cmp
    import regdst_hazard_pipe_pkg::*;
#(
    parameter int NREG_W = 5
) (
    input  logic [NREG_W-1:0] src,
    input  logic              uses,
    input  logic              mem_valid,
    input  logic              mem_wen,
    input  logic [NREG_W-1:0] mem_wreg,
    input  logic              wb_valid,
    input  logic              wb_wen,
    input  logic [NREG_W-1:0] wb_wreg,
    output logic [1:0]        sel
);

    logic src_live;
    logic mem_hit;
    logic wb_hit;

    assign src_live = uses && (src != '0);
    assign mem_hit  = src_live && mem_valid && mem_wen && (mem_wreg == src);
    assign wb_hit   = src_live && wb_valid && wb_wen && (wb_wreg == src);

    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/regdst_hazard_pipe.sv
// Carries ID destination-register numbers through EX/MEM/WB, detects load-use
// hazards, drives the EX forwarding selects and the register-file write port.
module regdst_hazard_pipe
    import regdst_hazard_pipe_pkg::*;
#(
    parameter int NREG_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] id_rs,
    input  logic [NREG_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [NREG_W-1:0] id_wreg,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              ex_flush,
    output logic              stall,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic [NREG_W-1:0] wb_wreg,
    output logic              wb_wen,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int SLOT_W = NREG_W + 2;

    logic [SLOT_W-1:0] ex_slot_reg, mem_slot_reg, wb_slot_reg;
    logic [SLOT_W-1:0] ex_slot_next;
    logic              ex_is_load_reg;
    logic [NREG_W-1:0] ex_rs_reg, ex_rt_reg;
    logic              ex_uses_rs_reg, ex_uses_rt_reg;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

    logic [NREG_W-1:0] ex_wreg, mem_wreg;
    logic              haz;
    logic              ex_take;

    assign ex_wreg  = ex_slot_reg[SLOT_WREG_LSB +: NREG_W];
    assign mem_wreg = mem_slot_reg[SLOT_WREG_LSB +: NREG_W];

    assign haz = ex_slot_reg[SLOT_VALID] && ex_slot_reg[SLOT_WEN] && ex_is_load_reg
              && (ex_wreg != '0) && id_valid
              && ((id_uses_rs && (id_rs == ex_wreg)) || (id_uses_rt && (id_rt == ex_wreg)));

    // A flushed ID instruction is discarded anyway, so it must not also stall.
    assign stall   = haz && !ex_flush;
    assign ex_take = id_valid && !stall && !ex_flush;

    assign ex_slot_next   = ex_take ? {id_wreg, id_wen, 1'b1} : '0;
    assign stall_cnt_next = (stall && (stall_cnt_reg != '1)) ? stall_cnt_reg + CNT_W'(1)
                                                             : stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot_reg    <= '0;
            mem_slot_reg   <= '0;
            wb_slot_reg    <= '0;
            ex_is_load_reg <= 1'b0;
            ex_rs_reg      <= '0;
            ex_rt_reg      <= '0;
            ex_uses_rs_reg <= 1'b0;
            ex_uses_rt_reg <= 1'b0;
            stall_cnt_reg  <= '0;
        end else begin
            wb_slot_reg    <= mem_slot_reg;
            mem_slot_reg   <= ex_slot_reg;
            ex_slot_reg    <= ex_slot_next;
            ex_is_load_reg <= ex_take && id_is_load;
            ex_rs_reg      <= ex_take ? id_rs : '0;
            ex_rt_reg      <= ex_take ? id_rt : '0;
            ex_uses_rs_reg <= ex_take && id_uses_rs;
            ex_uses_rt_reg <= ex_take && id_uses_rt;
            stall_cnt_reg  <= stall_cnt_next;
        end
    end

    fwd_cmp #(.NREG_W(NREG_W)) u_fwd_a (
        .src       (ex_rs_reg),
        .uses      (ex_uses_rs_reg),
        .mem_valid (mem_slot_reg[SLOT_VALID]),
        .mem_wen   (mem_slot_reg[SLOT_WEN]),
        .mem_wreg  (mem_wreg),
        .wb_valid  (wb_slot_reg[SLOT_VALID]),
        .wb_wen    (wb_slot_reg[SLOT_WEN]),
        .wb_wreg   (wb_wreg),
        .sel       (ex_fwd_a)
    );

    fwd_cmp #(.NREG_W(NREG_W)) u_fwd_b (
        .src       (ex_rt_reg),
        .uses      (ex_uses_rt_reg),
        .mem_valid (mem_slot_reg[SLOT_VALID]),
        .mem_wen   (mem_slot_reg[SLOT_WEN]),
        .mem_wreg  (mem_wreg),
        .wb_valid  (wb_slot_reg[SLOT_VALID]),
        .wb_wen    (wb_slot_reg[SLOT_WEN]),
        .wb_wreg   (wb_wreg),
        .sel       (ex_fwd_b)
    );

    assign wb_wreg   = wb_slot_reg[SLOT_WREG_LSB +: NREG_W];
    assign wb_wen    = wb_slot_reg[SLOT_VALID] && wb_slot_reg[SLOT_WEN];
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_regdst_hazard_pipe.sv
// Directed bench for regdst_hazard_pipe: a wide-counter instance and a 2-bit
// counter instance share stimulus; write-back results are scoreboarded.
module tb_regdst_hazard_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_wreg;
    logic       id_uses_rs, id_uses_rt, id_wen, id_is_load, ex_flush;

    logic        stall, wb_wen;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic [4:0]  wb_wreg;
    logic [15:0] stall_cnt;

    logic        s_stall, s_wb_wen;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [4:0]  s_wb_wreg;
    logic [1:0]  s_stall_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    int exp_cnt_sat = 0;
    logic [5:0] wb_q[$];

    always #5 clk = ~clk;

    regdst_hazard_pipe #(.NREG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wreg(id_wreg),
        .id_wen(id_wen), .id_is_load(id_is_load), .ex_flush(ex_flush),
        .stall(stall), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .wb_wreg(wb_wreg), .wb_wen(wb_wen), .stall_cnt(stall_cnt)
    );

    regdst_hazard_pipe #(.NREG_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wreg(id_wreg),
        .id_wen(id_wen), .id_is_load(id_is_load), .ex_flush(ex_flush),
        .stall(s_stall), .ex_fwd_a(s_fwd_a), .ex_fwd_b(s_fwd_b),
        .wb_wreg(s_wb_wreg), .wb_wen(s_wb_wen), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic reset_queue();
        wb_q.delete();
        for (int i = 0; i < 3; i++) wb_q.push_back(6'd0);
    endtask

    // One ID cycle: drive at negedge, check combinational outputs, log the WB expectation.
    task automatic cyc(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] wr, input logic wen,
                       input logic ld, input logic fl, input logic exp_st,
                       input logic [1:0] efa, input logic [1:0] efb);
        logic [5:0] e;
        logic       acc;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_wreg = wr; id_wen = wen; id_is_load = ld; ex_flush = fl;
        #1;
        chk({tag, "_cnt"}, stall_cnt, 16'(exp_cnt));
        chk({tag, "_satcnt"}, {14'd0, s_stall_cnt}, 16'(exp_cnt_sat));
        chk({tag, "_stall"}, {15'd0, stall}, {15'd0, exp_st});
        chk({tag, "_fwd_a"}, {14'd0, ex_fwd_a}, {14'd0, efa});
        chk({tag, "_fwd_b"}, {14'd0, ex_fwd_b}, {14'd0, efb});
        chk({tag, "_sat_fwd_a"}, {14'd0, s_fwd_a}, {14'd0, efa});
        e = wb_q.pop_front();
        chk({tag, "_wb_wreg"}, {11'd0, wb_wreg}, {11'd0, e[5:1]});
        chk({tag, "_wb_wen"}, {15'd0, wb_wen}, {15'd0, e[0]});
        chk({tag, "_sat_wb"}, {10'd0, s_wb_wreg, s_wb_wen}, {10'd0, e});
        acc = v && !exp_st && !fl;
        wb_q.push_back(acc ? {wr, wen} : 6'd0);
        if (exp_st) begin
            exp_cnt++;
            if (exp_cnt_sat < 3) exp_cnt_sat++;
        end
        $display("step %s: stall=%0b fwd_a=%0b fwd_b=%0b wb=%0d/%0b cnt=%0d",
                 tag, stall, ex_fwd_a, ex_fwd_b, wb_wreg, wb_wen, stall_cnt);
    endtask

    task automatic nop(input string tag, input logic [1:0] efa, input logic [1:0] efb);
        cyc(tag, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, efa, efb);
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_wreg = 0; id_wen = 0; id_is_load = 0; ex_flush = 0;
        #1;
        chk("init_stall", {15'd0, stall}, 16'd0);
        chk("init_fwd", {12'd0, ex_fwd_a, ex_fwd_b}, 16'd0);
        chk("init_wb", {10'd0, wb_wreg, wb_wen}, 16'd0);
        chk("init_cnt", stall_cnt, 16'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_queue();

        // Latency: wreg 9 at N reaches WB at N+3
        cyc("lat0", 1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00);
        nop("lat1", 2'b00, 2'b00);
        nop("lat2", 2'b00, 2'b00);
        nop("lat3", 2'b00, 2'b00);

        // Load-use: one stall, then dependent meets the load in WB
        cyc("lu0", 1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("lu1", 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 1, 2'b00, 2'b00);
        cyc("lu2", 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00);
        nop("lu3", 2'b01, 2'b00);

        // Priority: MEM over WB, then WB only once MEM stops writing
        cyc("pr0", 1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00);
        cyc("pr1", 1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00);
        cyc("pr2", 1, 5'd3, 5'd3, 1, 1, 5'd8, 1, 0, 0, 0, 2'b00, 2'b00);
        nop("pr3", 2'b10, 2'b10);
        cyc("pw0", 1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00);
        cyc("pw1", 1, 5'd0, 5'd0, 0, 0, 5'd3, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("pw2", 1, 5'd3, 5'd3, 1, 1, 5'd8, 1, 0, 0, 0, 2'b00, 2'b00);
        nop("pw3", 2'b01, 2'b01);

        // Register 0 neither stalls nor forwards
        cyc("z0", 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("z1", 1, 5'd0, 5'd0, 1, 0, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00);
        nop("z2", 2'b00, 2'b00);
        nop("z3", 2'b00, 2'b00);

        // Flush with a load-use hazard: no stall, bubble in EX
        cyc("fl0", 1, 5'd0, 5'd0, 0, 0, 5'd10, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("fl1", 1, 5'd10, 5'd0, 1, 0, 5'd11, 1, 0, 1, 0, 2'b00, 2'b00);
        cyc("fl2", 1, 5'd10, 5'd0, 1, 0, 5'd11, 1, 0, 0, 0, 2'b00, 2'b00);
        nop("fl3", 2'b01, 2'b00);

        // Five more stalls; the 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("sa%0d", i), 1, 5'd0, 5'd0, 0, 0, 5'd12, 1, 1, 0, 0, 2'b00, 2'b00);
            cyc($sformatf("sb%0d", i), 1, 5'd12, 5'd0, 1, 0, 5'd13, 1, 0, 0, 1, 2'b00, 2'b00);
            cyc($sformatf("sc%0d", i), 1, 5'd12, 5'd0, 1, 0, 5'd13, 1, 0, 0, 0, 2'b00, 2'b00);
            nop($sformatf("sd%0d", i), 2'b01, 2'b00);
        end
        nop("se", 2'b00, 2'b00);

        // Fill the pipe with writes to r7, then reset asynchronously between edges
        cyc("f1", 1, 5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 2'b00, 2'b00);
        cyc("f2", 1, 5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 2'b00, 2'b00);
        cyc("f3", 1, 5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 2'b10, 2'b00);
        cyc("f4", 1, 5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 2'b10, 2'b00);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wb_wen", {15'd0, wb_wen}, 16'd0);
        chk("rst_wb_wreg", {11'd0, wb_wreg}, 16'd0);
        chk("rst_fwd", {12'd0, ex_fwd_a, ex_fwd_b}, 16'd0);
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_cnt", stall_cnt, 16'd0);
        chk("rst_satcnt", {14'd0, s_stall_cnt}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        id_valid = 1'b0;
        exp_cnt = 0;
        exp_cnt_sat = 0;
        reset_queue();

        // Restart empty: no stale hazard or forward
        cyc("r0", 1, 5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0, 2'b00, 2'b00);
        nop("r1", 2'b00, 2'b00);
        nop("r2", 2'b00, 2'b00);
        nop("r3", 2'b00, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
